led_matrix_row_scanner: RTL

Sequential row-scan driver for the 5x7 LED matrix. Holds a double-buffered frame and cycles through the rows with a programmable dwell time and a blanking gap between rows. It drives the one-hot row enables, the column data for the active row, and the 3-bit row index that the row-select multiplexer tree consumes. New frames are loaded through a valid/ready handshake and take effect only on frame boundaries, so a frame is never torn mid-scan.

---
 rtl/led_matrix_row_scanner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/led_matrix_row_scanner.sv
// Row-scan driver for a small LED matrix: double-buffered frame, per-row dwell,
// optional blanking gap between rows, and tear-free frame swaps at scan boundaries.
module led_matrix_row_scanner #(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 7,
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [2:0]           row_sel,
  output logic [ROWS-1:0]      row_en,
  output logic [COLS-1:0]      col_data,
  output logic                 frame_done
);

  localparam int unsigned FW = ROWS * COLS;
  localparam int unsigned DW = $clog2(DWELL + 1);
  localparam int unsigned BW = $clog2(BLANK + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_DISPLAY, ST_BLANK} state_t;

  state_t          state;
  logic [FW-1:0]   active;
  logic [FW-1:0]   pending;
  logic            pend;
  logic [DW-1:0]   dwell_cnt;
  logic [BW-1:0]   blank_cnt;

  logic            dwell_last;
  logic            blank_last;
  logic            advance;
  logic            wrap;
  logic [2:0]      next_row;
  logic [FW-1:0]   wrap_buf;
  logic [FW-1:0]   start_buf;

  function automatic logic [COLS-1:0] row_bits(input logic [FW-1:0] f, input logic [2:0] r);
    row_bits = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (r == 3'(i)) row_bits = f[i*COLS +: COLS];
    end
  endfunction

  // Row sequencing: when the current row is finished and which buffer the next row reads.
  always_comb begin
    dwell_last = (dwell_cnt == DW'(DWELL - 1));
    blank_last = (blank_cnt == BW'(BLANK - 1));
    advance    = ((state == ST_DISPLAY) && dwell_last && (BLANK == 0)) ||
                 ((state == ST_BLANK) && blank_last);
    wrap       = (row_sel == 3'(ROWS - 1));
    next_row   = wrap ? 3'd0 : row_sel + 3'd1;
    wrap_buf   = (wrap && pend) ? pending : active;
    start_buf  = pend ? pending : active;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      active      <= '0;
      pending     <= '0;
      pend        <= 1'b0;
      dwell_cnt   <= '0;
      blank_cnt   <= '0;
      frame_ready <= 1'b1;
      row_sel     <= 3'd0;
      row_en      <= '0;
      col_data    <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Transfer and swap are exclusive: a transfer needs the pending slot empty.
      if (frame_valid && frame_ready) begin
        pending     <= frame_data;
        pend        <= 1'b1;
        frame_ready <= 1'b0;
      end
      if (!enable) begin
        state     <= ST_IDLE;
        row_sel   <= 3'd0;
        row_en    <= '0;
        col_data  <= '0;
        dwell_cnt <= '0;
        blank_cnt <= '0;
      end else if (advance) begin
        state     <= ST_DISPLAY;
        row_sel   <= next_row;
        dwell_cnt <= '0;
        blank_cnt <= '0;
        row_en    <= ROWS'(1) << next_row;
        col_data  <= row_bits(wrap_buf, next_row);
        if (wrap) begin
          frame_done <= 1'b1;
          if (pend) begin
            active      <= pending;
            pend        <= 1'b0;
            frame_ready <= 1'b1;
          end
        end
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_DISPLAY;
            row_sel   <= 3'd0;
            dwell_cnt <= '0;
            row_en    <= ROWS'(1);
            col_data  <= row_bits(start_buf, 3'd0);
            if (pend) begin
              active      <= pending;
              pend        <= 1'b0;
              frame_ready <= 1'b1;
            end
          end
          ST_DISPLAY: begin
            if (dwell_last) begin
              state     <= ST_BLANK;
              dwell_cnt <= '0;
              blank_cnt <= '0;
              row_en    <= '0;
              col_data  <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + DW'(1);
            end
          end
          ST_BLANK: blank_cnt <= blank_cnt + BW'(1);
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
